// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//
// Rate-change stage of a CIC decimation chain, placed between the last
// integrator and the first comb. It keeps every R-th input sample, where R is
// programmable at run time. Each kept sample is narrowed from IN_WIDTH to
// OUT_WIDTH bits by rounding (half up) or truncation, with positive
// saturation. The output strobe is the low-rate strobe for the comb cascade.
//
// Ports:
//   clk            clock
//   reset_n        asynchronous, active-low reset
//   samp_inp_data  signed integrator sample, valid while samp_inp_str=1
//   samp_inp_str   input sample strobe (contiguous or gapped)
//   rate           requested decimation factor, sampled at each emission;
//                  a value of 0 is treated as 1
//   sync           single-cycle phase resynchronisation request
//   samp_out_data  signed decimated sample, held between emissions
//   samp_out_str   one-cycle output strobe, 1 clk after the emitting input
//   sat_flag       sticky saturation indicator, cleared only by reset
// -----------------------------------------------------------------------------
module cic_decimator #(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 12,
  parameter int RATE_WIDTH   = 8,
  parameter int DEFAULT_RATE = 4,
  parameter int ROUND        = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [IN_WIDTH-1:0]  samp_inp_data,
  input  logic                        samp_inp_str,
  input  logic [RATE_WIDTH-1:0]       rate,
  input  logic                        sync,
  output logic signed [OUT_WIDTH-1:0] samp_out_data,
  output logic                        samp_out_str,
  output logic                        sat_flag
);

  localparam int SHIFT = IN_WIDTH - OUT_WIDTH;

  // Largest representable output value, expressed at the extended width so it
  // can be compared directly against the scaled sample.
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(SHIFT + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_OUT =
    {1'b0, {(OUT_WIDTH - 1){1'b1}}};

  logic [RATE_WIDTH-1:0]       cnt;
  logic [RATE_WIDTH-1:0]       rate_act;
  logic [RATE_WIDTH-1:0]       rate_req;
  logic [RATE_WIDTH-1:0]       rate_act_next;
  logic                        emit;
  logic signed [IN_WIDTH:0]    ext;
  logic signed [IN_WIDTH:0]    scaled;
  logic                        sat;
  logic signed [OUT_WIDTH-1:0] reduced;

  // ---------------------------------------------------------------------------
  // Phase control
  // ---------------------------------------------------------------------------
  assign rate_req      = (rate == '0) ? RATE_WIDTH'(1) : rate;
  assign emit          = samp_inp_str && ((cnt == '0) || sync);
  // The rate sampled at an emission governs the period that starts right away,
  // so the counter reload uses the incoming value, not the stored one.
  assign rate_act_next = emit ? rate_req : rate_act;

  // ---------------------------------------------------------------------------
  // Width reduction. The sample is widened by one bit so the rounding offset
  // cannot wrap, then arithmetically shifted. The comparison against SAT_MAX
  // over the full extended word catches the only possible overflow (a
  // positive value rounded up past the output range). Flooring can never
  // exceed the range, so the same check is simply never true in that case.
  // ---------------------------------------------------------------------------
  assign ext = {samp_inp_data[IN_WIDTH-1], samp_inp_data};

  generate
    if (ROUND != 0 && SHIFT > 0) begin : g_round
      localparam logic [IN_WIDTH:0] HALF = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
      assign scaled = (ext + $signed(HALF)) >>> SHIFT;
    end else begin : g_trunc
      assign scaled = ext >>> SHIFT;
    end
  endgenerate

  assign sat     = (scaled > SAT_MAX);
  assign reduced = sat ? SAT_OUT : scaled[OUT_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      rate_act      <= RATE_WIDTH'(DEFAULT_RATE);
      samp_out_data <= '0;
      samp_out_str  <= 1'b0;
      sat_flag      <= 1'b0;
    end else begin
      samp_out_str <= emit;
      rate_act     <= rate_act_next;
      if (emit) begin
        cnt           <= rate_act_next - RATE_WIDTH'(1);
        samp_out_data <= reduced;
        if (sat) begin
          sat_flag <= 1'b1;
        end
      end else if (samp_inp_str) begin
        cnt <= cnt - RATE_WIDTH'(1);
      end else if (sync) begin
        // Forces the next input strobe to be emitted.
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic_decimator
//
// Directed bench for cic_decimator. Two instances share all inputs: the main
// one rounds (ROUND=1), the second truncates (ROUND=0). Inputs are driven 1 ns
// after a rising edge; outputs are checked 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_cic_decimator;

  logic               clk;
  logic               reset_n;
  logic signed [15:0] data;
  logic               str;
  logic [7:0]         rate;
  logic               sync;

  logic signed [11:0] out_data;
  logic               out_str;
  logic               sat;
  logic signed [11:0] out_data_t;
  logic               out_str_t;
  logic               sat_t;

  int total_cnt = 0;
  int pass_cnt  = 0;

  cic_decimator #(
    .IN_WIDTH(16), .OUT_WIDTH(12), .RATE_WIDTH(8), .DEFAULT_RATE(4), .ROUND(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .samp_inp_data(data), .samp_inp_str(str), .rate(rate), .sync(sync),
    .samp_out_data(out_data), .samp_out_str(out_str), .sat_flag(sat)
  );

  cic_decimator #(
    .IN_WIDTH(16), .OUT_WIDTH(12), .RATE_WIDTH(8), .DEFAULT_RATE(4), .ROUND(0)
  ) dut_t (
    .clk(clk), .reset_n(reset_n),
    .samp_inp_data(data), .samp_inp_str(str), .rate(rate), .sync(sync),
    .samp_out_data(out_data_t), .samp_out_str(out_str_t), .sat_flag(sat_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    $display("check %-24s got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Sets inputs for one cycle and advances to just after the capturing edge.
  task automatic drive(input logic [15:0] d, input logic s, input logic sy);
    data = d;
    str  = s;
    sync = sy;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    str     = 1'b0;
    sync    = 1'b0;
    data    = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [12:0] gap_emit;
  logic [10:0] sync_emit;

  initial begin
    reset_n = 1'b0;
    data    = '0;
    str     = 1'b0;
    rate    = 8'd4;
    sync    = 1'b0;

    // ---- reset state and first sample ----
    tick();
    tick();
    chk("rst_str", 32'(out_str), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    reset_n = 1'b1;
    drive(16'h0100, 1'b1, 1'b0);
    chk("first_str", 32'(out_str), 32'd1);
    chk("first_data", 32'(out_data), 32'h010);
    drive(16'h0000, 1'b0, 1'b0);
    chk("first_str_drop", 32'(out_str), 32'd0);
    chk("first_data_hold", 32'(out_data), 32'h010);

    // ---- contiguous decimation, rate 4 ----
    do_reset();
    rate = 8'd4;
    for (int k = 0; k < 12; k++) begin
      drive(16'(16 * k), 1'b1, 1'b0);
      chk($sformatf("contig_str_k%0d", k), 32'(out_str), (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) chk($sformatf("contig_data_k%0d", k), 32'(out_data), 32'(k));
    end
    drive(16'h0000, 1'b0, 1'b0);
    chk("contig_tail_str", 32'(out_str), 32'd0);

    // ---- gapped input with rate change to 2, then to 0 (acts as 1) ----
    do_reset();
    rate     = 8'd4;
    gap_emit = 13'b1_1101_0101_0001; // bit k = emission expected for strobe k
    for (int k = 0; k < 13; k++) begin
      if (k == 2) rate = 8'd2;
      if (k == 9) rate = 8'd0;
      drive(16'(32 * k), 1'b1, 1'b0);
      chk($sformatf("gap_str_k%0d", k), 32'(out_str), 32'(gap_emit[k]));
      if (gap_emit[k]) chk($sformatf("gap_data_k%0d", k), 32'(out_data), 32'(2 * k));
      drive(16'h0000, 1'b0, 1'b0);
      chk($sformatf("gap_idle1_k%0d", k), 32'(out_str), 32'd0);
      drive(16'h0000, 1'b0, 1'b0);
    end

    // ---- rounding and saturation, rate 1 ----
    do_reset();
    rate = 8'd1;
    drive(16'h7FF8, 1'b1, 1'b0);
    chk("rnd_7ff8_data", 32'(out_data) & 32'hFFF, 32'h7FF);
    chk("rnd_7ff8_sat", 32'(sat), 32'd1);
    chk("trunc_7ff8_data", 32'(out_data_t) & 32'hFFF, 32'h7FF);
    chk("trunc_7ff8_sat", 32'(sat_t), 32'd0);
    drive(16'hFFF8, 1'b1, 1'b0);
    chk("rnd_fff8_str", 32'(out_str), 32'd1);
    chk("rnd_fff8_data", 32'(out_data) & 32'hFFF, 32'h000);
    chk("trunc_fff8_data", 32'(out_data_t) & 32'hFFF, 32'hFFF);
    drive(16'hFFF7, 1'b1, 1'b0);
    chk("rnd_fff7_data", 32'(out_data) & 32'hFFF, 32'hFFF);
    drive(16'h0017, 1'b1, 1'b0);
    chk("rnd_0017_data", 32'(out_data) & 32'hFFF, 32'h001);
    chk("rnd_sat_sticky", 32'(sat), 32'd1);
    drive(16'h0000, 1'b0, 1'b0);
    chk("rnd_sat_hold", 32'(sat), 32'd1);

    // ---- sync alone, then sync coincident with a strobe at cnt=2 ----
    do_reset();
    rate = 8'd4;
    drive(16'h0100, 1'b1, 1'b0);   // k0 emitted, cnt -> 3
    chk("sync_k0_str", 32'(out_str), 32'd1);
    drive(16'h0200, 1'b1, 1'b0);   // k1, cnt -> 2
    chk("sync_k1_str", 32'(out_str), 32'd0);
    drive(16'h0000, 1'b0, 1'b1);   // sync alone, cnt -> 0
    chk("sync_alone_str", 32'(out_str), 32'd0);
    sync_emit = 11'b100_0101_0001;
    for (int s = 0; s < 11; s++) begin
      drive(16'(16 * (s + 1)), 1'b1, (s == 6) ? 1'b1 : 1'b0);
      chk($sformatf("sync_str_s%0d", s), 32'(out_str), 32'(sync_emit[s]));
      if (sync_emit[s]) chk($sformatf("sync_data_s%0d", s), 32'(out_data), 32'(s + 1));
    end

    // ---- asynchronous reset mid-operation ----
    do_reset();
    rate = 8'd2;
    drive(16'h7FF8, 1'b1, 1'b0);   // emitted, saturates, cnt -> 1
    chk("mid_pre_sat", 32'(sat), 32'd1);
    drive(16'h0010, 1'b1, 1'b0);   // cnt -> 0
    chk("mid_k1_str", 32'(out_str), 32'd0);
    data = 16'h0020;               // k2 would be emitted at the next edge
    str  = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_async_sat", 32'(sat), 32'd0);
    tick();
    chk("mid_rst_str", 32'(out_str), 32'd0);
    chk("mid_rst_sat", 32'(sat), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    drive(16'h0000, 1'b0, 1'b0);
    chk("mid_rst_str2", 32'(out_str), 32'd0);
    reset_n = 1'b1;
    rate    = 8'd4;
    for (int k = 0; k < 5; k++) begin
      drive(16'(16 * k), 1'b1, 1'b0);
      chk($sformatf("post_rst_str_k%0d", k), 32'(out_str),
          (k == 0 || k == 4) ? 32'd1 : 32'd0);
    end
    chk("post_rst_sat", 32'(sat), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
